seq_mult: RTL and testbench
===========================

// Module: seq_mult
// PURPOSE
//  Parametrised sequential shift-and-add multiplier, one partial product per clock.
//  Replaces the combinational 4-bit array multiplier in the ALU's multiply path.
//  Uses a start/done handshake. Returns a 2*WIDTH-bit product split into hi/lo halves.
//  One WIDTH-bit ripple adder is reused every cycle, so area is O(WIDTH), not O(WIDTH^2).
// PARAMETERS
//  WIDTH   8   operand width in bits; legal range 2..32
// PORTS
//  clk     in   1      single clock; all state changes on rising edge
//  reset   in   1      synchronous, active-high reset
//  start   in   1      request; sampled only when ready (state IDLE or DONE)
//  a       in   WIDTH  multiplicand; captured on the accepting edge
//  b       in   WIDTH  multiplier; captured on the accepting edge
//  busy    out  1      high while state RUN
//  done    out  1      one-cycle pulse; hi/lo valid from this cycle on
//  hi      out  WIDTH  upper half of product
//  lo      out  WIDTH  lower half of product
// BEHAVIOUR
//  Reset (edge with reset=1): state IDLE; busy=0, done=0, hi=0, lo=0; cnt, acc, mq, mcand cleared.
//  reset has priority over everything, including mid-RUN: the operation is abandoned and no done pulse is produced.
//  States:
//   - IDLE: if start=1 -> load mcand=a, mq=b, acc=0, cnt=WIDTH; go to RUN.
//   - RUN: each edge does one step; cnt-=1; if cnt reaches 0 on this edge -> DONE.
//   - DONE: done=1 for exactly this cycle.
//       - start=1 here -> accept new operands and go to RUN (back-to-back, no idle bubble).
//       - otherwise -> IDLE.
//  Step: {c,s} = acc + (mq[0] ? mcand : 0) via ripple adder; {acc,mq} <= {c,s,mq} >> 1.
//  Latency: accepting edge E0; steps on E1..E_WIDTH; done high in the cycle after E_WIDTH.
//   - The next operation can therefore be accepted every WIDTH+1 cycles.
//  hi/lo are loaded only on the final step edge. They hold the last product through IDLE and through a later RUN.
//  start while RUN: ignored; no queueing.
//  Unsigned default: {hi,lo} = a*b exactly, including the max case (2^W-1)^2; no overflow possible.
//  a=0 or b=0: still takes WIDTH steps; product 0.
// CONFIGURATION
//  Macro: SEQ_MULT_SIGNED_EN
//  Defined:
//   - Extra input port `tc` (1 bit), captured with the operands.
//   - tc=1: a and b are two's complement. The magnitudes are multiplied. The result is negated on the final edge if sign(a)^sign(b).
//   - The most-negative operand, e.g. -128*-128 at W=8, yields +16384 correctly.
//   - tc=0: behaviour identical to the macro-undefined case.
//   - Latency is unchanged.
//  Undefined: no tc port; unsigned only.
// STRUCTURE
//  Package seq_mult_pkg:
//   - state enum {IDLE, RUN, DONE} (2-bit encoding)
//   - function clog2 for the cnt width (cnt is clog2(WIDTH+1) bits)
//  Sub-module ripple_add #(WIDTH):
//   - ports (s, cout, a, b, cin)
//   - chain of 1-bit full adders
//   - instantiated once for the step add. When SEQ_MULT_SIGNED_EN is defined, a second instance does the 2*WIDTH negate.
//  FSM and datapath registers live in seq_mult itself.
// TESTING
//  1. W=4, reset mid-RUN (two steps into 13*11): no done pulse; hi=0, lo=0; next start 3*5 -> {hi,lo}=15.
//  2. W=4, a=15, b=15, start 1 cycle: busy for 4 cycles; done pulse on cycle 5; {hi,lo}=225 (hi=14, lo=1).
//  3. W=8, 200*0 then 0*255: each gives done with product 0, after full latency (9 cycles per operation).
//  4. W=8, back-to-back: start held high in DONE; 17*19 then 255*255 -> 323, then 65025; no IDLE cycle between; done pulses exactly 9 cycles apart.
//  5. W=8, start pulsed again during RUN of 6*7: ignored; result 42; only one done pulse.
//  6. SEQ_MULT_SIGNED_EN, W=8, tc=1:
//     - -3*5 -> 16'hFFF1
//     - -128*-128 -> 16'h4000
//     - tc=0 with 8'h80*8'h80 -> 16'h4000 unsigned (128*128=16384)
//     - 8'hFF*8'h02 with tc=0 -> 510; with tc=1 -> -2 = 16'hFFFE
//  Random: 1000 pairs per WIDTH in {2,4,8,16}, compared against the '*' operator; hi/lo must be stable between done pulses.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier: FSM encoding and
// the width helper used to size the step counter.
package seq_mult_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Number of bits needed to hold values 0..n-1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ripple_add.sv
// Plain ripple-carry adder built from a chain of 1-bit full adders.
module ripple_add #(
  parameter int WIDTH = 8
) (
  output logic [WIDTH-1:0] s,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-and-add multiplier, one partial product per clock, start/done handshake.
// Optional two's-complement mode is enabled by defining SEQ_MULT_SIGNED_EN (adds input tc).
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic             tc,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Handshake: start is accepted on any edge where the FSM is in IDLE or DONE
  // (busy=0); done is a one-cycle pulse and hi/lo are valid from that cycle on.

  localparam int CW = clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  state_t state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   a_op;
  logic [WIDTH-1:0]   b_op;

  assign addend = mq_q[0] ? mcand_q : '0;

  ripple_add #(.WIDTH(WIDTH)) u_step (
    .s    (sum),
    .cout (carry),
    .a    (acc_q),
    .b    (addend),
    .cin  (1'b0)
  );

  // {acc,mq} after this step: the adder result with its carry, shifted right by one.
  assign prod_raw = {carry, sum, mq_q[WIDTH-1:1]};

`ifdef SEQ_MULT_SIGNED_EN
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] prod_neg;
  logic               neg_cout;

  // Operands are reduced to magnitudes; the most-negative value maps to 2^(W-1) unsigned.
  assign a_op = (tc && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_op = (tc && b[WIDTH-1]) ? (~b + 1'b1) : b;

  ripple_add #(.WIDTH(2 * WIDTH)) u_neg (
    .s    (prod_neg),
    .cout (neg_cout),
    .a    (~prod_raw),
    .b    ('0),
    .cin  (1'b1)
  );

  // A carry out of the negate only happens for a zero magnitude, which needs no negation.
  assign prod_fin = (neg_q && !neg_cout) ? prod_neg : prod_raw;
`else
  assign a_op     = a;
  assign b_op     = b;
  assign prod_fin = prod_raw;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef SEQ_MULT_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      ST_RUN: begin
        acc_d = prod_raw[2*WIDTH-1:WIDTH];
        mq_d  = prod_raw[WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d      = ST_DONE;
          {hi_d, lo_d} = prod_fin;
        end
      end
      default: begin
        if (start) begin
          state_d = ST_RUN;
          mcand_d = a_op;
          mq_d    = b_op;
          acc_d   = '0;
          cnt_d   = CNT_INIT;
`ifdef SEQ_MULT_SIGNED_EN
          neg_d   = tc & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: four instances (WIDTH 2/4/8/16), directed vector table, hand-written
// multi-cycle sequences and random operand pairs checked against the '*' operator.
module tb_seq_mult;

  logic clk;
  logic reset;

  logic start2, start4, start8, start16;
  logic [1:0]  a2, b2, hi2, lo2;
  logic [3:0]  a4, b4, hi4, lo4;
  logic [7:0]  a8, b8, hi8, lo8;
  logic [15:0] a16, b16, hi16, lo16;
  logic busy2, busy4, busy8, busy16;
  logic done2, done4, done8, done16;
`ifdef SEQ_MULT_SIGNED_EN
  logic tc;
`endif

  int checks;
  int errors;
  logic [31:0] prev_prod [4];

  typedef struct {
    int          sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        tc;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_mult #(.WIDTH(2)) u_m2 (
    .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2),
`ifdef SEQ_MULT_SIGNED_EN
    .tc(tc),
`endif
    .busy(busy2), .done(done2), .hi(hi2), .lo(lo2));

  seq_mult #(.WIDTH(4)) u_m4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
`ifdef SEQ_MULT_SIGNED_EN
    .tc(tc),
`endif
    .busy(busy4), .done(done4), .hi(hi4), .lo(lo4));

  seq_mult #(.WIDTH(8)) u_m8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
`ifdef SEQ_MULT_SIGNED_EN
    .tc(tc),
`endif
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8));

  seq_mult #(.WIDTH(16)) u_m16 (
    .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16),
`ifdef SEQ_MULT_SIGNED_EN
    .tc(tc),
`endif
    .busy(busy16), .done(done16), .hi(hi16), .lo(lo16));

  // helpers
  function automatic int width_of(input int sel);
    case (sel)
      0: return 2;
      1: return 4;
      2: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0: return busy2;
      1: return busy4;
      2: return busy8;
      default: return busy16;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0: return done2;
      1: return done4;
      2: return done8;
      default: return done16;
    endcase
  endfunction

  function automatic logic [31:0] get_prod(input int sel);
    case (sel)
      0: return {28'd0, hi2, lo2};
      1: return {24'd0, hi4, lo4};
      2: return {16'd0, hi8, lo8};
      default: return {hi16, lo16};
    endcase
  endfunction

  task automatic drive(input int sel, input logic s, input logic [15:0] av, input logic [15:0] bv);
    case (sel)
      0: begin start2 = s; a2 = av[1:0]; b2 = bv[1:0]; end
      1: begin start4 = s; a4 = av[3:0]; b4 = bv[3:0]; end
      2: begin start8 = s; a8 = av[7:0]; b8 = bv[7:0]; end
      default: begin start16 = s; a16 = av; b16 = bv; end
    endcase
  endtask

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // One complete operation: start pulse, wait for done, check latency/busy/product/stability.
  task automatic run_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                        input logic [31:0] exp, input string name);
    int w;
    int lat;
    int busy_n;
    logic stable;
    logic [31:0] got;
    w = width_of(sel);
    @(negedge clk);
    drive(sel, 1'b1, av, bv);
    @(posedge clk);
    #1 drive(sel, 1'b0, av, bv);
    lat = -1;
    busy_n = 0;
    stable = 1'b1;
    got = '0;
    for (int i = 0; i <= w + 4 && lat < 0; i++) begin
      @(negedge clk);
      if (get_done(sel)) begin
        lat = i;
        got = get_prod(sel);
      end else begin
        if (get_busy(sel)) busy_n++;
        if (get_prod(sel) !== prev_prod[sel]) stable = 1'b0;
      end
    end
    chk({name, "_latency"}, lat, w);
    chk({name, "_busy_cycles"}, busy_n, w);
    chk({name, "_product"}, got, exp);
    chk({name, "_hold_stable"}, {31'd0, stable}, 32'd1);
    prev_prod[sel] = exp;
    @(negedge clk);
    chk({name, "_done_one_cycle"}, {31'd0, get_done(sel)}, 32'd0);
  endtask

  initial begin : main
    int first;
    int second;
    int busy_n;
    int n_done;
    int lat;
    logic [31:0] got;
    logic [15:0] ra;
    logic [15:0] rb;
    int w;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    for (int s = 0; s < 4; s++) begin
      drive(s, 1'b0, 16'd0, 16'd0);
      prev_prod[s] = '0;
    end
`ifdef SEQ_MULT_SIGNED_EN
    tc = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("reset_w%0d", width_of(s)),
          {29'd0, get_busy(s), get_done(s), |get_prod(s)}, 32'd0);
    end
    reset = 1'b0;

    // directed vectors
    vecs.push_back('{2, 16'd200, 16'd0,   1'b0, 32'd0,          "w8_200x0"});
    vecs.push_back('{2, 16'd0,   16'd255, 1'b0, 32'd0,          "w8_0x255"});
    vecs.push_back('{0, 16'd3,   16'd3,   1'b0, 32'd9,          "w2_3x3"});
    vecs.push_back('{0, 16'd2,   16'd1,   1'b0, 32'd2,          "w2_2x1"});
    vecs.push_back('{3, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16_max"});
    vecs.push_back('{2, 16'd255, 16'd255, 1'b0, 32'd65025,      "w8_max"});
    vecs.push_back('{1, 16'd15,  16'd15,  1'b0, 32'd225,        "w4_15x15"});
`ifdef SEQ_MULT_SIGNED_EN
    vecs.push_back('{2, 16'hFD, 16'h05, 1'b1, 32'h0000FFF1, "s8_m3x5"});
    vecs.push_back('{2, 16'h80, 16'h80, 1'b1, 32'h00004000, "s8_m128xm128"});
    vecs.push_back('{2, 16'h80, 16'h80, 1'b0, 32'h00004000, "u8_128x128"});
    vecs.push_back('{2, 16'hFF, 16'h02, 1'b0, 32'h000001FE, "u8_255x2"});
    vecs.push_back('{2, 16'hFF, 16'h02, 1'b1, 32'h0000FFFE, "s8_m1x2"});
    vecs.push_back('{2, 16'h05, 16'hFD, 1'b1, 32'h0000FFF1, "s8_5xm3"});
    vecs.push_back('{2, 16'h00, 16'h80, 1'b1, 32'h00000000, "s8_0xm128"});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
`ifdef SEQ_MULT_SIGNED_EN
      tc = vecs[i].tc;
`endif
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
    end
`ifdef SEQ_MULT_SIGNED_EN
    tc = 1'b0;
`endif

    // W=4 reset two steps into 13*11: abandoned, no done, outputs cleared
    n_done = 0;
    @(negedge clk);
    drive(1, 1'b1, 16'd13, 16'd11);
    @(posedge clk);
    #1 drive(1, 1'b0, 16'd13, 16'd11);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    if (done4) n_done++;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int s = 0; s < 4; s++) prev_prod[s] = '0;
    @(negedge clk);
    chk("midrun_reset_busy", {31'd0, busy4}, 32'd0);
    chk("midrun_reset_product", get_prod(1), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done4) n_done++;
    end
    chk("midrun_reset_no_done", n_done, 0);
    run_op(1, 16'd3, 16'd5, 32'd15, "w4_after_reset_3x5");

    // W=8 back-to-back with start held high through DONE
    first = -1;
    second = -1;
    busy_n = 0;
    @(negedge clk);
    drive(2, 1'b1, 16'd17, 16'd19);
    @(posedge clk);
    for (int i = 0; i <= 30 && second < 0; i++) begin
      @(negedge clk);
      if (done8) begin
        if (first < 0) begin
          first = i;
          chk("b2b_first_product", get_prod(2), 32'd323);
          drive(2, 1'b1, 16'd255, 16'd255);
        end else begin
          second = i;
          chk("b2b_second_product", get_prod(2), 32'd65025);
          drive(2, 1'b0, 16'd0, 16'd0);
        end
      end else if (busy8) begin
        busy_n++;
      end
    end
    chk("b2b_first_latency", first, 8);
    chk("b2b_done_spacing", second - first, 9);
    chk("b2b_no_idle_bubble", busy_n, 16);
    prev_prod[2] = 32'd65025;

    // W=8 start pulsed during RUN of 6*7 is ignored
    n_done = 0;
    lat = -1;
    got = '0;
    @(negedge clk);
    drive(2, 1'b1, 16'd6, 16'd7);
    @(posedge clk);
    #1 drive(2, 1'b0, 16'd6, 16'd7);
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) drive(2, 1'b1, 16'd9, 16'd9);
      if (i == 4) drive(2, 1'b0, 16'd9, 16'd9);
      if (done8) begin
        n_done++;
        if (lat < 0) begin
          lat = i;
          got = get_prod(2);
        end
      end
    end
    chk("ignore_start_done_count", n_done, 1);
    chk("ignore_start_latency", lat, 8);
    chk("ignore_start_product", got, 32'd42);
    prev_prod[2] = 32'd42;

    // random pairs per width
    for (int s = 0; s < 4; s++) begin
      w = width_of(s);
      for (int n = 0; n < 1000; n++) begin
        ra = 16'($urandom_range(0, (1 << w) - 1));
        rb = 16'($urandom_range(0, (1 << w) - 1));
        run_op(s, ra, rb, 32'(ra) * 32'(rb), $sformatf("rand_w%0d_%0d", w, n));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
